pkt_fifo_reader: RTL and testbench
==================================

Name: pkt_fifo_reader

Overview:
- Drains framed packets from a single-clock FIFO_RAM instance: the read-side counterpart of the packet writer that fills it.
- Each packet is one header word followed by N payload words. Header bits [LEN_WIDTH-1:0] hold N.
- Pops words with o_fifo_rd_en, which has 1-cycle registered read latency and may only be asserted while the FIFO is not empty.
- Strips the header and presents the payload as a valid/ready stream with first/last markers.

Parameters:
- WIDTH, 16: FIFO word width and output data width.
- LEN_WIDTH, 12: width of the header length field (N), taken from header bits [LEN_WIDTH-1:0]. Must satisfy LEN_WIDTH < WIDTH.
- CNT_WIDTH, 16: width of the packet statistics counter.

Ports:
- i_clk  in  1  clock; all logic is on its rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_fifo_rd_en  out  1  FIFO pop request.
- i_fifo_rd_data  in  WIDTH  FIFO read data; valid the cycle after o_fifo_rd_en.
- i_fifo_empty  in  1  FIFO empty flag.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the beat.
- o_data  out  WIDTH  payload word.
- o_first  out  1  beat is the first payload word of its packet.
- o_last  out  1  beat is the last payload word of its packet.
- o_err_len  out  1  one-cycle pulse when a header with N==0 is dropped.
- o_pkt_count  out  CNT_WIDTH  count of packets whose last beat was accepted; wraps.

Behaviour:
- Reset values (i_rst high, applied immediately and asynchronously):
  - o_fifo_rd_en=0, o_valid=0, o_data=0, o_first=0, o_last=0, o_err_len=0, o_pkt_count=0.
  - FSM=S_IDLE, buffer empty, in-flight flag cleared, remaining-read count cleared.
  - Reset mid-packet abandons the packet. The system resets the FIFO in the same cycle.
- FSM states:
  - S_IDLE: o_fifo_rd_en = !i_fifo_empty. On a pop, go to S_HDR.
  - S_HDR: i_fifo_rd_data is the header; no pop in this state.
    - If N==0: pulse o_err_len for one cycle, go to S_IDLE.
    - Else: load rd_rem=N, set first_pending=1, go to S_BODY.
  - S_BODY: o_fifo_rd_en = !i_fifo_empty && rd_rem!=0 && (buf_cnt + inflight - pop) < 2.
    - pop = o_valid && i_ready. This is a combinational path from i_ready to o_fifo_rd_en.
    - Each issued read decrements rd_rem.
    - When the read with rd_rem==1 is issued, mark it last. Go to S_IDLE once that last word's data has been returned and pushed.
  - The next header may be popped while earlier beats are still buffered. Per-beat flags keep framing correct.
- Returned-data path:
  - When inflight==1, i_fifo_rd_data is pushed into a 2-entry output buffer, tagged with its first/last flags.
  - The first payload read of a packet carries first=1 and clears first_pending.
  - o_data, o_first and o_last come from the buffer head. o_valid = (buf_cnt != 0).
- Latency:
  - Header pop in cycle T, first payload pop in T+2, data returns in T+3, o_valid in T+4.
  - With i_ready held high and FIFO non-empty, throughput is then 1 beat/cycle.
- Buffer rules:
  - The buffer never overflows: the in-flight accounting guarantees buf_cnt ≤ 2.
  - Push and pop in the same cycle are both honoured.
  - o_data, o_first and o_last stay stable while o_valid && !i_ready.
- o_fifo_rd_en is never asserted while i_fifo_empty=1.
- If the FIFO runs empty mid-packet, the block stalls in S_BODY indefinitely. There is no timeout.
- o_pkt_count increments on accepting a beat with o_last=1, and wraps from 2^CNT_WIDTH-1 to 0.
- N=2^LEN_WIDTH-1 (4095) is legal. rd_rem is LEN_WIDTH bits wide.
- Header bits above LEN_WIDTH are ignored.

Decomposition:
- Package pkt_reader_pkg holds:
  - State encoding S_IDLE/S_HDR/S_BODY.
  - Header field constants: LEN_LSB=0, len_of() helper.
  - Buffer depth constant SKID_DEPTH=2.
- Sub-module pkt_skid_buf: a 2-entry registered buffer with push, pop, count and data+first+last storage.
- Top-level pkt_fifo_reader holds the FSM, in-flight tracking and statistics counter.

Test Plan:
- Single packet: FIFO preloaded with 0x0003, 0xA1, 0xB2, 0xC3; i_ready=1.
  - Exactly 4 pops.
  - Beats A1(first), B2, C3(last) on consecutive cycles, first beat 4 cycles after the header pop.
  - o_pkt_count=1.
- Zero length: headers 0x0000, then 0x0001, payload 0x55.
  - o_err_len is high for exactly 1 cycle.
  - Then a single beat 0x55 with first=1 and last=1.
  - o_pkt_count=1.
- Backpressure: 8-word packet, i_ready low for 5 cycles after beat 2.
  - At most 2 beats buffered; no pops while the buffer is full.
  - All 8 beats delivered in order with stable data while stalled.
- FIFO underrun: 4-word packet whose last 2 words are written 10 cycles late.
  - o_fifo_rd_en stays 0 while the FIFO is empty.
  - Stream resumes and o_last falls on word 4.
- Async reset mid-packet: assert i_rst between clock edges during beat 3 of 6.
  - All outputs drop to 0 before the next edge.
  - After release, a fresh 2-word packet is framed correctly.
- Back-to-back and wrap: 3 packets of lengths 1, 4095, 2 with no gaps.
  - Framing flags are correct across packet boundaries.
  - With CNT_WIDTH=2, o_pkt_count sequence is 1, 2, 3, then 0 after a 4th packet.

Source files
------------

// File: rtl/pkt_reader_pkg.sv
// Shared types and constants for the packet FIFO reader: FSM encoding,
// header field layout and output buffer depth.
package pkt_reader_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_BODY = 2'd2
    } state_t;

    localparam int LEN_LSB    = 0;
    localparam int SKID_DEPTH = 2;

    // Extracts the payload length field (len_w bits starting at LEN_LSB).
    function automatic logic [31:0] len_of(input logic [31:0] hdr, input int len_w);
        logic [31:0] mask;
        mask = (32'd1 << len_w) - 32'd1;
        return (hdr >> LEN_LSB) & mask;
    endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// Two-entry registered output buffer holding payload words with their
// first/last framing flags; the head entry drives the stream outputs.
module pkt_skid_buf
    import pkt_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_first,
    input  logic             i_last,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_first,
    output logic             o_last,
    output logic [1:0]       o_count
);

    localparam int EW = WIDTH + 2;

    logic [EW-1:0] r_head;
    logic [EW-1:0] r_tail;
    logic [EW-1:0] w_in;
    logic [1:0]    r_cnt;

    assign w_in = {i_first, i_last, i_data};

    // The head only changes on a pop or when the buffer is empty, which keeps
    // the presented beat stable under backpressure.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_cnt != 2'(SKID_DEPTH)) begin
                        if (r_cnt == 2'd0) r_head <= w_in;
                        else               r_tail <= w_in;
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_head <= w_in;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data  = r_head[WIDTH-1:0];
    assign o_last  = r_head[WIDTH];
    assign o_first = r_head[WIDTH+1];
    assign o_count = r_cnt;

endmodule

// File: rtl/pkt_fifo_reader.sv
// Drains header-framed packets from a registered-read FIFO and presents the
// payload as a valid/ready stream with first/last markers.
module pkt_fifo_reader
    import pkt_reader_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LEN_WIDTH = 12,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    output logic                 o_fifo_rd_en,
    input  logic [WIDTH-1:0]     i_fifo_rd_data,
    input  logic                 i_fifo_empty,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic                 o_first,
    output logic                 o_last,
    output logic                 o_err_len,
    output logic [CNT_WIDTH-1:0] o_pkt_count
);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [LEN_WIDTH-1:0] r_rd_rem;
    logic [LEN_WIDTH-1:0] w_hdr_len;
    logic                 r_first_pend;
    logic                 r_inflight;
    logic                 r_infl_first;
    logic                 r_infl_last;
    logic [CNT_WIDTH-1:0] r_pkt_count;
    logic [1:0]           w_buf_cnt;
    logic [2:0]           w_occ;
    logic                 w_pop;
    logic                 w_rd_en;
    logic                 w_body_rd;
    logic                 w_err;

    assign w_hdr_len = LEN_WIDTH'(len_of(32'(i_fifo_rd_data), LEN_WIDTH));
    assign w_pop     = o_valid && i_ready;
    // Buffer occupancy after this cycle's pop, counting the word still in flight.
    assign w_occ     = {1'b0, w_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_body_rd = w_rd_en && (r_state == S_BODY);

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_rd_en = !i_fifo_empty && !i_rst;
                if (w_rd_en) w_state_nxt = S_HDR;
            end
            S_HDR: begin
                if (w_hdr_len == '0) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_BODY;
                end
            end
            S_BODY: begin
                w_rd_en = !i_fifo_empty && (r_rd_rem != '0) && (w_occ < 3'd2);
                if (r_inflight && r_infl_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_rd_rem     <= '0;
            r_first_pend <= 1'b0;
            r_inflight   <= 1'b0;
            r_infl_first <= 1'b0;
            r_infl_last  <= 1'b0;
            r_pkt_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_inflight   <= w_body_rd;
            r_infl_first <= w_body_rd && r_first_pend;
            r_infl_last  <= w_body_rd && (r_rd_rem == LEN_WIDTH'(1));
            if (r_state == S_HDR && w_hdr_len != '0) begin
                r_rd_rem     <= w_hdr_len;
                r_first_pend <= 1'b1;
            end else if (w_body_rd) begin
                r_rd_rem     <= r_rd_rem - LEN_WIDTH'(1);
                r_first_pend <= 1'b0;
            end
            if (w_pop && o_last) r_pkt_count <= r_pkt_count + CNT_WIDTH'(1);
        end
    end

    pkt_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_inflight),
        .i_data  (i_fifo_rd_data),
        .i_first (r_infl_first),
        .i_last  (r_infl_last),
        .i_pop   (w_pop),
        .o_data  (o_data),
        .o_first (o_first),
        .o_last  (o_last),
        .o_count (w_buf_cnt)
    );

    assign o_valid      = (w_buf_cnt != 2'd0);
    assign o_fifo_rd_en = w_rd_en;
    assign o_err_len    = w_err;
    assign o_pkt_count  = r_pkt_count;

endmodule

// File: tb/tb_pkt_fifo_reader.sv
// Randomized bench for pkt_fifo_reader: queue-based FIFO model and an
// expected-beat scoreboard derived from the packet framing rules.
module tb_pkt_fifo_reader;

    localparam int WIDTH     = 16;
    localparam int LEN_WIDTH = 12;
    localparam int CNT_WIDTH = 2;

    logic                 i_clk;
    logic                 i_rst;
    logic                 o_fifo_rd_en;
    logic [WIDTH-1:0]     i_fifo_rd_data;
    logic                 i_fifo_empty;
    logic                 o_valid;
    logic                 i_ready;
    logic [WIDTH-1:0]     o_data;
    logic                 o_first;
    logic                 o_last;
    logic                 o_err_len;
    logic [CNT_WIDTH-1:0] o_pkt_count;

    pkt_fifo_reader #(
        .WIDTH     (WIDTH),
        .LEN_WIDTH (LEN_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_fifo_rd_en   (o_fifo_rd_en),
        .i_fifo_rd_data (i_fifo_rd_data),
        .i_fifo_empty   (i_fifo_empty),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_first        (o_first),
        .o_last         (o_last),
        .o_err_len      (o_err_len),
        .o_pkt_count    (o_pkt_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // FIFO contents (word + header tag) and expected beats {first,last,data}
    logic [WIDTH-1:0] fifo_q[$];
    bit               fifo_tag[$];
    logic [17:0]      exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ncyc = 0;
    int payload_popped, accepted, total_pops, model_cnt, err_seen, exp_err;
    int last_hdr_n, first_n, last_n;
    bit rand_ready;
    bit prev_stall;
    logic [17:0] prev_beat;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        fifo_q.delete();
        fifo_tag.delete();
        exp_q.delete();
        payload_popped = 0;
        accepted       = 0;
        total_pops     = 0;
        model_cnt      = 0;
        err_seen       = 0;
        exp_err        = 0;
        prev_stall     = 1'b0;
        i_fifo_rd_data = '0;
        i_fifo_empty   = 1'b1;
    endtask

    // One clock: observe at negedge, then update FIFO model just after posedge.
    task automatic tick();
        bit          do_pop;
        bit          tag;
        logic [17:0] ed;
        @(negedge i_clk);
        ncyc++;
        do_pop = 1'b0;
        if (!i_rst) begin
            check_eq("rd_en_when_empty", 64'(o_fifo_rd_en & i_fifo_empty), 64'd0);
            check_eq("outstanding_le2", 64'((payload_popped - accepted) <= 2), 64'd1);
            if (o_err_len) err_seen++;
            if (prev_stall && o_valid)
                check_eq("stall_stable", 64'({o_first, o_last, o_data}), 64'(prev_beat));
            prev_stall = o_valid && !i_ready;
            prev_beat  = {o_first, o_last, o_data};
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", 64'(o_valid), 64'd0);
                end else begin
                    ed = exp_q.pop_front();
                    check_eq("beat_data", 64'(o_data), 64'(ed[15:0]));
                    check_eq("beat_first_last", 64'({o_first, o_last}), 64'(ed[17:16]));
                    check_eq("pkt_count_run", 64'(o_pkt_count), 64'(model_cnt % 4));
                    if (ed[16]) model_cnt++;
                end
                if (o_first) first_n = ncyc;
                if (o_last)  last_n  = ncyc;
                accepted++;
            end
            if (o_fifo_rd_en && fifo_q.size() != 0) begin
                do_pop = 1'b1;
                if (fifo_tag[0]) last_hdr_n = ncyc;
            end
        end
        @(posedge i_clk);
        #1;
        if (do_pop) begin
            i_fifo_rd_data = fifo_q.pop_front();
            tag = fifo_tag.pop_front();
            total_pops++;
            if (!tag) payload_popped++;
        end
        i_fifo_empty = (fifo_q.size() == 0);
        if (rand_ready) i_ready = ($urandom_range(3) != 0);
    endtask

    task automatic put_word(input logic [WIDTH-1:0] w, input bit hdr);
        fifo_q.push_back(w);
        fifo_tag.push_back(hdr);
        i_fifo_empty = 1'b0;
    endtask

    task automatic put_hdr(input int n, input logic [3:0] hi);
        put_word({hi, 12'(n)}, 1'b1);
        if (n == 0) exp_err++;
    endtask

    task automatic put_pay(input int idx, input int n, input logic [WIDTH-1:0] w);
        put_word(w, 1'b0);
        exp_q.push_back({(idx == 0), (idx == n - 1), w});
    endtask

    task automatic put_pkt(input int n);
        put_hdr(n, 4'($urandom_range(15)));
        for (int i = 0; i < n; i++) put_pay(i, n, 16'($urandom));
    endtask

    task automatic drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0) && t < budget) begin
            tick();
            t++;
        end
        check_eq("drain_done", 64'(exp_q.size() + fifo_q.size()), 64'd0);
        repeat (3) tick();
    endtask

    task automatic wait_accepted(input int k, input int budget);
        int t;
        t = 0;
        while (accepted < k && t < budget) begin
            tick();
            t++;
        end
        check_eq("wait_accepted", 64'(accepted >= k), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        clear_model();
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
    endtask

    initial begin
        i_rst      = 1'b1;
        i_ready    = 1'b1;
        rand_ready = 1'b0;
        prev_beat  = '0;
        last_hdr_n = 0;
        first_n    = 0;
        last_n     = 0;
        clear_model();
        repeat (2) @(posedge i_clk);
        #1;
        check_eq("reset_rd_en", 64'(o_fifo_rd_en), 64'd0);
        check_eq("reset_valid", 64'(o_valid), 64'd0);
        check_eq("reset_data", 64'({o_data, o_first, o_last}), 64'd0);
        check_eq("reset_err", 64'(o_err_len), 64'd0);
        check_eq("reset_count", 64'(o_pkt_count), 64'd0);
        i_rst = 1'b0;
        tick();

        // Single packet with latency and pop count
        put_hdr(3, 4'h0);
        put_pay(0, 3, 16'h00A1);
        put_pay(1, 3, 16'h00B2);
        put_pay(2, 3, 16'h00C3);
        drain(50);
        check_eq("single_latency", 64'(first_n - last_hdr_n), 64'd4);
        check_eq("single_consecutive", 64'(last_n - first_n), 64'd2);
        check_eq("single_pops", 64'(total_pops), 64'd4);
        check_eq("single_count", 64'(o_pkt_count), 64'd1);

        // Zero-length header dropped, then a one-word packet
        do_reset();
        put_hdr(0, 4'h0);
        put_hdr(1, 4'h0);
        put_pay(0, 1, 16'h0055);
        drain(50);
        check_eq("zero_err_cycles", 64'(err_seen), 64'd1);
        check_eq("zero_count", 64'(o_pkt_count), 64'd1);

        // Backpressure: stall 5 cycles after beat 2
        do_reset();
        put_pkt(8);
        wait_accepted(2, 50);
        i_ready = 1'b0;
        repeat (5) tick();
        check_eq("bp_held", 64'(accepted), 64'd2);
        check_eq("bp_valid_held", 64'(o_valid), 64'd1);
        i_ready = 1'b1;
        drain(100);
        check_eq("bp_beats", 64'(accepted), 64'd8);

        // Underrun: last two words arrive 10 cycles late
        do_reset();
        put_hdr(4, 4'h5);
        put_pay(0, 4, 16'h1111);
        put_pay(1, 4, 16'h2222);
        repeat (10) tick();
        check_eq("underrun_stalled", 64'(accepted), 64'd2);
        put_pay(2, 4, 16'h3333);
        put_pay(3, 4, 16'h4444);
        drain(50);
        check_eq("underrun_count", 64'(o_pkt_count), 64'd1);

        // Asynchronous reset between edges during beat 3 of 6
        do_reset();
        put_pkt(6);
        wait_accepted(2, 50);
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("arst_rd_en", 64'(o_fifo_rd_en), 64'd0);
        check_eq("arst_valid", 64'(o_valid), 64'd0);
        check_eq("arst_data", 64'({o_data, o_first, o_last}), 64'd0);
        check_eq("arst_err", 64'(o_err_len), 64'd0);
        clear_model();
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        put_pkt(2);
        drain(50);
        check_eq("arst_after_count", 64'(o_pkt_count), 64'd1);

        // Back-to-back 1, 4095, 2 then a fourth packet to wrap the counter
        do_reset();
        put_pkt(1);
        put_pkt(4095);
        put_pkt(2);
        drain(9000);
        check_eq("wrap_count3", 64'(o_pkt_count), 64'd3);
        put_pkt(3);
        drain(50);
        check_eq("wrap_count0", 64'(o_pkt_count), 64'd0);

        // Random packets, random ready, random write gaps
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < 30; p++) begin
            put_pkt(($urandom_range(9) == 0) ? 0 : int'($urandom_range(12, 1)));
            repeat ($urandom_range(3)) tick();
        end
        drain(3000);
        rand_ready = 1'b0;
        i_ready    = 1'b1;
        tick();
        check_eq("rand_err_count", 64'(err_seen), 64'(exp_err));
        check_eq("rand_pkt_count", 64'(o_pkt_count), 64'(model_cnt % 4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
